// File: rtl/sdram_wb_arbiter.sv
// Two-requester pipelined Wishbone arbiter in front of an SDRAM controller.
// Ports: clk, rst (async, active-high); requester ports m0_*/m1_*
//   (cyc, stb, we, sel, addr, data in; data, stall, ack out); slave port
//   s_* (cyc, stb, we, sel, addr, data out; stall, ack, data in).
module sdram_wb_arbiter #(
    parameter int   LGOUT  = 3,
    parameter logic OPT_RR = 1'b1,
    parameter int   AW     = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [31:0]   m0_data_i,
    output logic [31:0]   m0_data_o,
    output logic          m0_stall_o,
    output logic          m0_ack_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [31:0]   m1_data_i,
    output logic [31:0]   m1_data_o,
    output logic          m1_stall_o,
    output logic          m1_ack_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_sel_o,
    output logic [AW-1:0] s_addr_o,
    output logic [31:0]   s_data_o,
    input  logic          s_stall_i,
    input  logic          s_ack_i,
    input  logic [31:0]   s_data_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    localparam logic [LGOUT-1:0] CMAX = '1;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic             last_grant;
    logic [LGOUT-1:0] count;
    logic             full;
    logic             own0;
    logic             own1;
    logic             accept;

    assign own0 = (state == OWN0);
    assign own1 = (state == OWN1);
    assign full = (count == CMAX);

    // State resets asynchronously to IDLE, so every output below falls to
    // its idle value as soon as rst rises, without waiting for a clock.
    always_comb begin
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        m0_stall_o = 1'b1;
        m1_stall_o = 1'b1;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        if (own0) begin
            s_cyc_o    = m0_cyc_i;
            s_stb_o    = m0_stb_i & ~full;
            m0_stall_o = s_stall_i | full;
            m0_ack_o   = s_ack_i;
        end else if (own1) begin
            s_cyc_o    = m1_cyc_i;
            s_stb_o    = m1_stb_i & ~full;
            m1_stall_o = s_stall_i | full;
            m1_ack_o   = s_ack_i;
        end
    end

    assign s_we_o    = own1 ? m1_we_i   : m0_we_i;
    assign s_sel_o   = own1 ? m1_sel_i  : m0_sel_i;
    assign s_addr_o  = own1 ? m1_addr_i : m0_addr_i;
    assign s_data_o  = own1 ? m1_data_i : m0_data_i;
    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;

    assign accept = s_stb_o & ~s_stall_i;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    // On a tie, round-robin favours whoever did not win last.
                    if (OPT_RR && !last_grant)
                        state_nx = OWN1;
                    else
                        state_nx = OWN0;
                end else if (m0_cyc_i) begin
                    state_nx = OWN0;
                end else if (m1_cyc_i) begin
                    state_nx = OWN1;
                end
            end
            OWN0:    if (!m0_cyc_i) state_nx = IDLE;
            OWN1:    if (!m1_cyc_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            count      <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx != IDLE)
                last_grant <= (state_nx == OWN1);
            // Dropping cyc aborts the burst: outstanding acks are forgotten,
            // and acks arriving while idle never reach the counter.
            if (state == IDLE || state_nx == IDLE)
                count <= '0;
            else if (accept && !s_ack_i)
                count <= count + 1'b1;
            else if (!accept && s_ack_i && count != '0)
                count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Self-checking bench for sdram_wb_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_sdram_wb_arbiter;

    localparam int AW   = 32;
    localparam int MAXC = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]    m0_sel_i;
    logic [AW-1:0] m0_addr_i;
    logic [31:0]   m0_data_i, m0_data_o;
    logic          m0_stall_o, m0_ack_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]    m1_sel_i;
    logic [AW-1:0] m1_addr_i;
    logic [31:0]   m1_data_i, m1_data_o;
    logic          m1_stall_o, m1_ack_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]    s_sel_o;
    logic [AW-1:0] s_addr_o;
    logic [31:0]   s_data_o;
    logic          s_stall_i, s_ack_i;
    logic [31:0]   s_data_i;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the slave (-1 = nobody), who won the last
    // tie-relevant grant, and how many requests are in flight.
    int owner = -1;
    int lastg = 1;
    int cnt   = 0;

    always #5 clk = ~clk;

    sdram_wb_arbiter #(.LGOUT(3), .OPT_RR(1'b1), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
        .m0_data_o(m0_data_o), .m0_stall_o(m0_stall_o), .m0_ack_o(m0_ack_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
        .m1_data_o(m1_data_o), .m1_stall_o(m1_stall_o), .m1_ack_o(m1_ack_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o),
        .s_stall_i(s_stall_i), .s_ack_i(s_ack_i), .s_data_i(s_data_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic c[2], s[2], w[2];
        logic [3:0] sl[2];
        logic [31:0] a[2], d[2];
        logic fl, acc;
        c[0] = m0_cyc_i;  c[1] = m1_cyc_i;
        s[0] = m0_stb_i;  s[1] = m1_stb_i;
        w[0] = m0_we_i;   w[1] = m1_we_i;
        sl[0] = m0_sel_i; sl[1] = m1_sel_i;
        a[0] = m0_addr_i; a[1] = m1_addr_i;
        d[0] = m0_data_i; d[1] = m1_data_i;
        chk("m0_data", m0_data_o, s_data_i);
        chk("m1_data", m1_data_o, s_data_i);
        chk("count", 32'(dut.count), cnt);
        if (owner < 0) begin
            chk("s_cyc_idle", 32'(s_cyc_o), 0);
            chk("s_stb_idle", 32'(s_stb_o), 0);
            chk("m0_stall_idle", 32'(m0_stall_o), 1);
            chk("m1_stall_idle", 32'(m1_stall_o), 1);
            chk("m0_ack_idle", 32'(m0_ack_o), 0);
            chk("m1_ack_idle", 32'(m1_ack_o), 0);
        end else begin
            fl  = (cnt == MAXC);
            acc = s[owner] && !fl;
            chk("s_cyc", 32'(s_cyc_o), 32'(c[owner]));
            chk("s_stb", 32'(s_stb_o), 32'(acc));
            chk("s_we", 32'(s_we_o), 32'(w[owner]));
            chk("s_sel", 32'(s_sel_o), 32'(sl[owner]));
            chk("s_addr", s_addr_o, a[owner]);
            chk("s_data", s_data_o, d[owner]);
            chk("m0_stall", 32'(m0_stall_o),
                (owner == 0) ? 32'(s_stall_i || fl) : 32'd1);
            chk("m1_stall", 32'(m1_stall_o),
                (owner == 1) ? 32'(s_stall_i || fl) : 32'd1);
            chk("m0_ack", 32'(m0_ack_o),
                (owner == 0) ? 32'(s_ack_i) : 32'd0);
            chk("m1_ack", 32'(m1_ack_o),
                (owner == 1) ? 32'(s_ack_i) : 32'd0);
        end
    endtask

    task automatic model_update();
        logic cyc_o, acc;
        if (rst) begin
            owner = -1; lastg = 1; cnt = 0;
        end else if (owner < 0) begin
            cnt = 0;
            if (m0_cyc_i && m1_cyc_i) owner = (lastg == 0) ? 1 : 0;
            else if (m0_cyc_i) owner = 0;
            else if (m1_cyc_i) owner = 1;
            if (owner >= 0) lastg = owner;
        end else begin
            cyc_o = (owner == 0) ? m0_cyc_i : m1_cyc_i;
            acc = ((owner == 0) ? m0_stb_i : m1_stb_i)
                  && (cnt < MAXC) && !s_stall_i;
            if (!cyc_o) begin
                owner = -1; cnt = 0;
            end else if (acc && !s_ack_i) begin
                cnt = cnt + 1;
            end else if (!acc && s_ack_i && cnt > 0) begin
                cnt = cnt - 1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        s_stall_i = 0; s_ack_i = 0;
    endtask

    initial begin
        int exp_own[3];
        exp_own[0] = 0; exp_own[1] = 1; exp_own[2] = 0;
        rst = 1;
        idle_inputs();
        m0_we_i = 0; m0_sel_i = 4'hf; m0_addr_i = 32'h1000;
        m0_data_i = 32'haaaa_0000;
        m1_we_i = 1; m1_sel_i = 4'h3; m1_addr_i = 32'h2000;
        m1_data_i = 32'hbbbb_0000;
        s_data_i = 32'h1234_5678;
        #3;
        check_outputs();
        @(posedge clk); #1;
        rst = 0;

        // Round-robin ties: m0, m1, m0
        for (int k = 0; k < 3; k++) begin
            m0_cyc_i = 1; m1_cyc_i = 1;
            cycle();
            chk("tie_m0_stall", 32'(m0_stall_o), 32'(exp_own[k] != 0));
            chk("tie_m1_stall", 32'(m1_stall_o), 32'(exp_own[k] != 1));
            cycle();
            m0_cyc_i = 0; m1_cyc_i = 0;
            cycle();
        end

        // Burst flow control: 7 in flight then stall
        m0_cyc_i = 1; m0_stb_i = 1;
        cycle();
        repeat (7) cycle();
        chk("burst_cnt7", 32'(dut.count), 7);
        chk("burst_stall8", 32'(m0_stall_o), 1);
        chk("burst_stb8", 32'(s_stb_o), 0);
        s_ack_i = 1;
        cycle();
        s_ack_i = 0;
        chk("burst_stb_after_ack", 32'(s_stb_o), 1);
        chk("burst_nostall", 32'(m0_stall_o), 0);
        cycle();
        chk("burst_cnt_refill", 32'(dut.count), 7);
        idle_inputs();
        cycle();

        // Ownership hold
        m0_cyc_i = 1;
        cycle();
        m1_cyc_i = 1;
        for (int k = 0; k < 20; k++) begin
            s_ack_i = 1'($urandom_range(0, 1));
            cycle();
            chk("hold_m1_stall", 32'(m1_stall_o), 1);
            chk("hold_m1_ack", 32'(m1_ack_o), 0);
        end
        s_ack_i = 0; m0_cyc_i = 0;
        cycle();
        chk("hold_idle_m1_stall", 32'(m1_stall_o), 1);
        cycle();
        chk("hold_m1_granted", 32'(m1_stall_o), 0);
        idle_inputs();
        cycle();

        // Abort with 2 outstanding, late acks ignored
        m0_cyc_i = 1; m0_stb_i = 1;
        cycle();
        cycle();
        cycle();
        chk("abort_cnt2", 32'(dut.count), 2);
        idle_inputs();
        cycle();
        s_ack_i = 1;
        repeat (2) begin
            cycle();
            chk("abort_m0_ack", 32'(m0_ack_o), 0);
            chk("abort_m1_ack", 32'(m1_ack_o), 0);
            chk("abort_cnt0", 32'(dut.count), 0);
            chk("abort_idle", 32'(s_cyc_o), 0);
        end
        idle_inputs();
        cycle();

        // Simultaneous accept and ack at count 3
        m0_cyc_i = 1; m0_stb_i = 1;
        cycle();
        repeat (3) cycle();
        chk("simul_cnt3", 32'(dut.count), 3);
        s_ack_i = 1;
        cycle();
        chk("simul_hold3", 32'(dut.count), 3);
        idle_inputs();
        cycle();

        // Asynchronous reset during OWN1
        m1_cyc_i = 1; m1_stb_i = 1;
        cycle();
        chk("rst_own1_cyc", 32'(s_cyc_o), 1);
        #3 rst = 1;
        #1;
        chk("rst_async_cyc", 32'(s_cyc_o), 0);
        chk("rst_async_stb", 32'(s_stb_o), 0);
        chk("rst_async_stall", 32'(m1_stall_o), 1);
        owner = -1; lastg = 1; cnt = 0;
        @(posedge clk); #1;
        rst = 0;
        m0_cyc_i = 1; m1_cyc_i = 1; m1_stb_i = 0;
        cycle();
        chk("rst_tie_m0", 32'(m0_stall_o), 0);
        chk("rst_tie_m1", 32'(m1_stall_o), 1);
        idle_inputs();
        cycle();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) m0_cyc_i = ~m0_cyc_i;
            if ($urandom_range(0, 7) == 0) m1_cyc_i = ~m1_cyc_i;
            m0_stb_i  = 1'($urandom_range(0, 1));
            m1_stb_i  = 1'($urandom_range(0, 1));
            m0_we_i   = 1'($urandom_range(0, 1));
            m1_we_i   = 1'($urandom_range(0, 1));
            m0_sel_i  = 4'($urandom);
            m1_sel_i  = 4'($urandom);
            m0_addr_i = $urandom;
            m1_addr_i = $urandom;
            m0_data_i = $urandom;
            m1_data_i = $urandom;
            s_data_i  = $urandom;
            s_stall_i = ($urandom_range(0, 3) == 0);
            s_ack_i   = ($urandom_range(0, 2) == 0);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
